pcl_unit: RTL and testbench
===========================

// Module: pcl_unit
// PURPOSE
//  Program-counter low byte (PCL) of the 65C02 core. Holds PCL and performs increment,
//  loads and relative-branch add. On a page crossing it requests the PCH fixup via a
//  four-phase carry/borrow handshake, so PCL+PCH form the 16-bit PC.
//  Sits directly upstream of PCH: drives carry_to_pch/pch_dec, consumes carry_done.
// PARAMETERS
//  VEC_NMI      8'hFA  PCL value loaded by push_vector when vector_sel=2'b00
//  VEC_RES      8'hFC  PCL value loaded by push_vector when vector_sel=2'b01
//  VEC_IRQ      8'hFE  PCL value loaded by push_vector when vector_sel=2'b10/2'b11
//  HS_TIMEOUT   15     cycles without carry_done transition before hs_error is set
// PORTS
//  fclk                  in   1  core clock; all state changes on rising edge
//  reset                 in   1  synchronous, active-high reset
//  instruction_decode_in in   1  load PCL from db_in
//  adb_to_pc             in   1  load PCL from address_low_in
//  push_vector           in   1  load PCL with vector selected by vector_sel
//  vector_sel            in   2  vector select (see PARAMETERS)
//  branch_take           in   1  add signed branch_offset to PCL
//  branch_offset         in   8  two's-complement relative offset
//  pc_inc                in   1  PCL <= PCL+1
//  db_in                 in   8  data bus in
//  address_low_in        in   8  address bus low byte in
//  carry_done            in   1  PCH acknowledge (high while PCH services request)
//  db_out                out  8  current PCL onto data bus
//  address_low_out       out  8  current PCL onto address bus low
//  carry_to_pch          out  1  request PCH += 1
//  pch_dec               out  1  request PCH -= 1
//  busy                  out  1  high whenever FSM is not IDLE
//  hs_error              out  1  sticky: handshake timeout occurred
// BEHAVIOUR
//  - reset: PCL=8'h00, carry_to_pch=0, pch_dec=0, busy=0, hs_error=0, FSM=IDLE,
//    timeout counter=0. reset wins over every command and aborts any handshake.
//  - db_out = address_low_out = PCL (registered; new value visible 1 cycle after cmd).
//  - Command priority (sampled only in IDLE, all ignored while busy=1):
//    instruction_decode_in > adb_to_pc > push_vector > branch_take > pc_inc.
//  - Loads never request a PCH fixup.
//  - pc_inc: {co,PCL} = PCL+1 (9-bit); co=1 (FF->00) -> go REQ_UP.
//  - branch_take: {co,sum} = {1'b0,PCL}+{1'b0,branch_offset}; PCL<=sum.
//    offset[7]=0 & co=1 -> REQ_UP; offset[7]=1 & co=0 -> REQ_DN; else stay IDLE.
//    offset 8'h00 is a legal no-op add.
//  - FSM states: IDLE, REQ_UP, REQ_DN, RELEASE.
//    IDLE    : carry_to_pch=pch_dec=0; transitions above on the cmd edge.
//    REQ_UP  : carry_to_pch=1; carry_done==1 -> RELEASE.
//    REQ_DN  : pch_dec=1; carry_done==1 -> RELEASE.
//    RELEASE : both requests 0; carry_done==0 -> IDLE.
//    Request asserted the cycle after the cmd edge; min handshake = 3 cycles to IDLE.
//  - carry_done high while in IDLE is ignored (no state change).
//  - Timeout: counter clears on each state entry, counts while in REQ_*/RELEASE;
//    reaching HS_TIMEOUT sets hs_error (sticky until reset), drops requests, -> IDLE.
//  - PCL itself never changes while busy; back-to-back incs stall via busy.
// TESTING
//  1 reset; pc_inc x3 -> PCL 00,01,02,03; carry_to_pch never asserted; busy=0.
//  2 db_in=8'hFF load, pc_inc -> PCL=00, carry_to_pch=1 next cycle; carry_done=1 ->
//    request drops; carry_done=0 -> busy=0; pc_inc during busy ignored (PCL stays 00).
//  3 PCL=8'hF0, branch_offset=8'h20 -> PCL=10, REQ_UP; PCL=8'h10, offset=8'hE0 ->
//    PCL=F0, pch_dec=1; PCL=8'h10, offset=8'hF0 -> PCL=00, no request.
//  4 push_vector with vector_sel=00/01/10/11 -> PCL=FA/FC/FE/FE, no request;
//    instruction_decode_in & pc_inc same cycle -> load wins, PCL=db_in.
//  5 REQ_UP with carry_done held 0 for 15 cycles -> hs_error=1, carry_to_pch=0, IDLE.
//  6 reset asserted mid REQ_DN -> next cycle PCL=00, pch_dec=0, busy=0, hs_error=0.

Source files
------------

// File: rtl/pcl_unit.sv
// Program-counter low byte of the 65C02 core: increment, loads, relative branch,
// plus a four-phase carry/borrow handshake that asks PCH to fix up on a page crossing.
module pcl_unit #(
   parameter logic [7:0] VEC_NMI    = 8'hFA,
   parameter logic [7:0] VEC_RES    = 8'hFC,
   parameter logic [7:0] VEC_IRQ    = 8'hFE,
   parameter int         HS_TIMEOUT = 15
) (
   input  logic       fclk,
   input  logic       reset,
   input  logic       instruction_decode_in,
   input  logic       adb_to_pc,
   input  logic       push_vector,
   input  logic [1:0] vector_sel,
   input  logic       branch_take,
   input  logic [7:0] branch_offset,
   input  logic       pc_inc,
   input  logic [7:0] db_in,
   input  logic [7:0] address_low_in,
   input  logic       carry_done,
   output logic [7:0] db_out,
   output logic [7:0] address_low_out,
   output logic       carry_to_pch,
   output logic       pch_dec,
   output logic       busy,
   output logic       hs_error
);

   localparam int CW = $clog2(HS_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ_UP, REQ_DN, RELEASE} state_e;

   state_e        state_q, state_d;
   logic [7:0]    pcl_q, pcl_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hs_error_q, hs_error_d;
   logic [8:0]    sum;
   logic [7:0]    vec;

   always_comb begin
      case (vector_sel)
         2'b00:   vec = VEC_NMI;
         2'b01:   vec = VEC_RES;
         default: vec = VEC_IRQ;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
      state_d    = state_q;
      pcl_d      = pcl_q;
      cnt_d      = cnt_q + 1'b1;
      hs_error_d = hs_error_q;
      sum        = '0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (instruction_decode_in) begin
               pcl_d = db_in;
            end else if (adb_to_pc) begin
               pcl_d = address_low_in;
            end else if (push_vector) begin
               pcl_d = vec;
            end else if (branch_take) begin
               // Carry out with a positive offset crosses up; no carry with a negative one crosses down.
               sum   = {1'b0, pcl_q} + {1'b0, branch_offset};
               pcl_d = sum[7:0];
               if (!branch_offset[7] && sum[8]) begin
                  state_d = REQ_UP;
               end else if (branch_offset[7] && !sum[8]) begin
                  state_d = REQ_DN;
               end
            end else if (pc_inc) begin
               sum   = {1'b0, pcl_q} + 9'd1;
               pcl_d = sum[7:0];
               if (sum[8]) begin
                  state_d = REQ_UP;
               end
            end
         end
         REQ_UP, REQ_DN: begin
            if (carry_done) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
         end
         RELEASE: begin
            if (!carry_done) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Handshake progress in the same cycle beats the timeout.
      if (state_q != IDLE && state_d == state_q && cnt_d == CW'(HS_TIMEOUT)) begin
         hs_error_d = 1'b1;
         state_d    = IDLE;
         cnt_d      = '0;
      end
   end

   always_ff @(posedge fclk) begin
      // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
      if (reset) begin
         state_q    <= IDLE;
         pcl_q      <= 8'h00;
         cnt_q      <= '0;
         hs_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcl_q      <= pcl_d;
         cnt_q      <= cnt_d;
         hs_error_q <= hs_error_d;
      end
   end

   assign db_out          = pcl_q;
   assign address_low_out = pcl_q;
   assign carry_to_pch    = (state_q == REQ_UP);
   assign pch_dec         = (state_q == REQ_DN);
   assign busy            = (state_q != IDLE);
   assign hs_error        = hs_error_q;

endmodule

// File: tb/tb_pcl_unit.sv
// Bench for pcl_unit: directed scenarios followed by random commands and a random PCH
// responder, all compared every cycle against a PC-arithmetic reference model.
module tb_pcl_unit;

   logic       fclk = 1'b0;
   logic       reset = 1'b0;
   logic       instruction_decode_in = 1'b0;
   logic       adb_to_pc = 1'b0;
   logic       push_vector = 1'b0;
   logic [1:0] vector_sel = 2'b00;
   logic       branch_take = 1'b0;
   logic [7:0] branch_offset = 8'h00;
   logic       pc_inc = 1'b0;
   logic [7:0] db_in = 8'h00;
   logic [7:0] address_low_in = 8'h00;
   logic       carry_done = 1'b0;
   logic [7:0] db_out;
   logic [7:0] address_low_out;
   logic       carry_to_pch;
   logic       pch_dec;
   logic       busy;
   logic       hs_error;

   pcl_unit dut (
      .fclk                  (fclk),
      .reset                 (reset),
      .instruction_decode_in (instruction_decode_in),
      .adb_to_pc             (adb_to_pc),
      .push_vector           (push_vector),
      .vector_sel            (vector_sel),
      .branch_take           (branch_take),
      .branch_offset         (branch_offset),
      .pc_inc                (pc_inc),
      .db_in                 (db_in),
      .address_low_in        (address_low_in),
      .carry_done            (carry_done),
      .db_out                (db_out),
      .address_low_out       (address_low_out),
      .carry_to_pch          (carry_to_pch),
      .pch_dec               (pch_dec),
      .busy                  (busy),
      .hs_error              (hs_error)
   );

   always #5 fclk = ~fclk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: PCL as an integer, the pending PCH adjustment (+1/-1/0),
   // whether we wait for the acknowledge to drop, and cycles spent waiting.
   int m_pcl  = 0;
   int m_req  = 0;
   bit m_rel  = 1'b0;
   int m_wait = 0;
   bit m_err  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int signed_off(input logic [7:0] off);
      return off[7] ? int'(off) - 256 : int'(off);
   endfunction

   task automatic apply_target(input int target);
      m_pcl  = target & 255;
      m_req  = (target > 255) ? 1 : (target < 0) ? -1 : 0;
      m_wait = 0;
   endtask

   task automatic model_edge();
      if (reset) begin
         m_pcl = 0; m_req = 0; m_rel = 1'b0; m_wait = 0; m_err = 1'b0;
      end else if (m_req == 0 && !m_rel) begin
         if (instruction_decode_in)   m_pcl = int'(db_in);
         else if (adb_to_pc)          m_pcl = int'(address_low_in);
         else if (push_vector)        m_pcl = (vector_sel == 2'b00) ? 'hFA : (vector_sel == 2'b01) ? 'hFC : 'hFE;
         else if (branch_take)        apply_target(m_pcl + signed_off(branch_offset));
         else if (pc_inc)             apply_target(m_pcl + 1);
      end else if (m_req != 0 && carry_done) begin
         m_req = 0; m_rel = 1'b1; m_wait = 0;
      end else if (m_rel && !carry_done) begin
         m_rel = 1'b0; m_wait = 0;
      end else begin
         m_wait++;
         if (m_wait == 15) begin
            m_err = 1'b1; m_req = 0; m_rel = 1'b0; m_wait = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("pcl_db",  db_out,          m_pcl);
      check("pcl_adl", address_low_out, m_pcl);
      check("carry",   carry_to_pch,    m_req == 1);
      check("dec",     pch_dec,         m_req == -1);
      check("busy",    busy,            (m_req != 0) || m_rel);
      check("hs_err",  hs_error,        m_err);
   endtask

   // One clock: inputs already driven, model advances on the edge, outputs checked 1 ns later,
   // then the single-cycle command pulses are cleared.
   task automatic tick();
      @(posedge fclk);
      model_edge();
      #1;
      compare_all();
      reset = 1'b0; instruction_decode_in = 1'b0; adb_to_pc = 1'b0;
      push_vector = 1'b0; branch_take = 1'b0; pc_inc = 1'b0;
   endtask

   task automatic load(input logic [7:0] v);
      instruction_decode_in = 1'b1; db_in = v; tick();
   endtask

   task automatic branch(input logic [7:0] off);
      branch_take = 1'b1; branch_offset = off; tick();
   endtask

   task automatic finish_hs();
      carry_done = 1'b1; tick();
      carry_done = 1'b0; tick();
   endtask

   logic [7:0] vec_exp [4];
   int mode;

   initial begin
      vec_exp[0] = 8'hFA; vec_exp[1] = 8'hFC; vec_exp[2] = 8'hFE; vec_exp[3] = 8'hFE;

      // 1: reset and plain increments
      reset = 1'b1; tick();
      check("rst_pcl", db_out, 8'h00);
      for (int i = 1; i <= 3; i++) begin
         pc_inc = 1'b1; tick();
         check("inc_pcl", db_out, i);
         check("inc_nocarry", carry_to_pch, 1'b0);
      end

      // 2: FF->00 wrap with handshake; increments while busy are ignored
      load(8'hFF);
      pc_inc = 1'b1; tick();
      check("wrap_pcl", db_out, 8'h00);
      check("wrap_carry", carry_to_pch, 1'b1);
      pc_inc = 1'b1; tick();
      check("busy_pcl", db_out, 8'h00);
      carry_done = 1'b1; tick();
      check("ack_drop", carry_to_pch, 1'b0);
      check("ack_busy", busy, 1'b1);
      carry_done = 1'b0; pc_inc = 1'b1; tick();
      check("rel_idle", busy, 1'b0);
      check("rel_pcl", db_out, 8'h00);

      // 3: branches across and within the page
      load(8'hF0); branch(8'h20);
      check("br_up_pcl", db_out, 8'h10);
      check("br_up_req", carry_to_pch, 1'b1);
      finish_hs();
      load(8'h10); branch(8'hE0);
      check("br_dn_pcl", db_out, 8'hF0);
      check("br_dn_req", pch_dec, 1'b1);
      finish_hs();
      load(8'h10); branch(8'hF0);
      check("br_in_pcl", db_out, 8'h00);
      check("br_in_busy", busy, 1'b0);
      branch(8'h00);
      check("br_zero", db_out, 8'h00);

      // 4: vectors and command priority
      for (int v = 0; v < 4; v++) begin
         push_vector = 1'b1; vector_sel = 2'(v); tick();
         check("vec_pcl", db_out, vec_exp[v]);
         check("vec_busy", busy, 1'b0);
      end
      instruction_decode_in = 1'b1; pc_inc = 1'b1; db_in = 8'h5A; tick();
      check("prio_pcl", db_out, 8'h5A);

      // 5: handshake timeout
      load(8'hFF);
      pc_inc = 1'b1; tick();
      for (int i = 0; i < 14; i++) tick();
      check("to_pending", carry_to_pch, 1'b1);
      tick();
      check("to_err", hs_error, 1'b1);
      check("to_carry", carry_to_pch, 1'b0);
      check("to_busy", busy, 1'b0);

      // 6: reset in the middle of a decrement request
      load(8'h10); branch(8'hE0); tick();
      reset = 1'b1; tick();
      check("rst_mid_pcl", db_out, 8'h00);
      check("rst_mid_dec", pch_dec, 1'b0);
      check("rst_mid_err", hs_error, 1'b0);

      // Random commands with a PCH responder that is sometimes prompt, sometimes stuck
      mode = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) mode = $urandom_range(0, 3);
         reset                 = ($urandom_range(0, 255) == 0);
         instruction_decode_in = ($urandom_range(0, 15) == 0);
         adb_to_pc             = ($urandom_range(0, 15) == 0);
         push_vector           = ($urandom_range(0, 15) == 0);
         vector_sel            = 2'($urandom_range(0, 3));
         branch_take           = ($urandom_range(0, 3) == 0);
         branch_offset         = 8'($urandom);
         pc_inc                = ($urandom_range(0, 1) == 0);
         db_in                 = $urandom_range(0, 1) ? (8'hF0 | 8'($urandom_range(0, 15))) : 8'($urandom);
         address_low_in        = 8'($urandom);
         carry_done            = (mode == 3) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
